// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: walks each instruction through the shared
// ALU / unified memory datapath one step per cycle, stalls on memory,
// and counts retired instructions.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | read instruction at PC, PC+4 into PC when memory is ready
// DECODE | read registers, precompute branch target into ALUOut
// MEMADR | compute effective address A + sign-ext imm
// MEMRD  | load data from memory at ALUOut (waits for mem_ready)
// MEMWB  | write MDR to register rt
// MEMWR  | store B to memory at ALUOut (waits for mem_ready)
// REX    | R-type ALU operation A funct B
// ALUWB  | write ALUOut to register rd
// BEQ    | compare A-B, load branch target when zero
// ADDIEX | A + sign-ext imm
// ADDIWB | write ALUOut to register rt
// JUMP   | load jump target into PC
module multicycle_control #(
  parameter logic [5:0] RTYPE_OP = 6'h00,
  parameter logic [5:0] LW_OP    = 6'h23,
  parameter logic [5:0] SW_OP    = 6'h2B,
  parameter logic [5:0] BEQ_OP   = 6'h04,
  parameter logic [5:0] ADDI_OP  = 6'h08,
  parameter logic [5:0] J_OP     = 6'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        pc_en,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] REX    = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BEQ    = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  logic [3:0] next_state;
  logic       retire;
  logic       pc_write;
  logic       branch;

  // state register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst)         instr_count <= 32'd0;
    else if (retire) instr_count <= instr_count + 32'd1;
  end

  // next-state decode and retirement detection
  always_comb begin
    next_state = FETCH;
    retire     = 1'b0;
    case (state)
      FETCH:  next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opcode == LW_OP || opcode == SW_OP) next_state = MEMADR;
        else if (opcode == RTYPE_OP)            next_state = REX;
        else if (opcode == BEQ_OP)              next_state = BEQ;
        else if (opcode == ADDI_OP)             next_state = ADDIEX;
        else if (opcode == J_OP)                next_state = JUMP;
        else                                    next_state = FETCH;
      end
      MEMADR: begin
        if (opcode == LW_OP)      next_state = MEMRD;
        else if (opcode == SW_OP) next_state = MEMWR;
        else                      next_state = FETCH;
      end
      MEMRD:  next_state = mem_ready ? MEMWB : MEMRD;
      MEMWB:  retire = 1'b1;
      MEMWR: begin
        next_state = mem_ready ? FETCH : MEMWR;
        retire     = mem_ready;
      end
      REX:    next_state = ALUWB;
      ALUWB:  retire = 1'b1;
      BEQ:    retire = 1'b1;
      ADDIEX: next_state = ADDIWB;
      ADDIWB: retire = 1'b1;
      JUMP:   retire = 1'b1;
      default: next_state = FETCH;
    endcase
  end

  // Moore strobes per state, all gated low while reset is held
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !(opcode == LW_OP || opcode == SW_OP || opcode == RTYPE_OP ||
                       opcode == BEQ_OP || opcode == ADDI_OP || opcode == J_OP);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_src    = 2'b01;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
    end
    pc_en = pc_write | (branch & zero);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams
// checked cycle by cycle against an instruction-level reference.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic        reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int          checks;
  int          failures;
  logic [31:0] exp_cnt;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  logic [15:0] dut_vec;
  assign dut_vec = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Strobe table straight from the per-state description.
  function automatic logic [15:0] exp_vec(input int st, input bit rdy, input bit zv, input bit ill);
    bit io = 0, mr = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, asa = 0, pce = 0, il = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pce = rdy; end
      1:  begin asb = 2'b11; il = ill; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin io = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pce = zv; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin psrc = 2'b10; pce = 1; end
      default: ;
    endcase
    return {io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pce, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, advance.
  task automatic cyc(input int st, input bit rdy, input bit zv, input logic [5:0] op, input bit ill);
    opcode    = (st == 0) ? 6'($urandom) : op;
    zero      = zv;
    mem_ready = rdy;
    #2;
    chk("state", 32'(state), 32'(st));
    chk("strobes", 32'(dut_vec), rst ? 32'd0 : 32'(exp_vec(st, rdy, zv, ill)));
    chk("instr_count", instr_count, exp_cnt);
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h08 || op == 6'h02;
  endfunction

  // Expands one instruction into its expected cycle list, then plays it.
  task automatic run_instr(input logic [5:0] op, input bit z, input int sf, input int sm);
    int sts[$];
    bit rdys[$];
    bit legal;
    legal = is_legal(op);
    for (int i = 0; i < sf; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
    sts.push_back(0); rdys.push_back(1'b1);
    sts.push_back(1); rdys.push_back(1'($urandom));
    case (op)
      6'h23: begin
        sts.push_back(2); rdys.push_back(1'($urandom));
        for (int i = 0; i < sm; i++) begin sts.push_back(3); rdys.push_back(1'b0); end
        sts.push_back(3); rdys.push_back(1'b1);
        sts.push_back(4); rdys.push_back(1'($urandom));
      end
      6'h2B: begin
        sts.push_back(2); rdys.push_back(1'($urandom));
        for (int i = 0; i < sm; i++) begin sts.push_back(5); rdys.push_back(1'b0); end
        sts.push_back(5); rdys.push_back(1'b1);
      end
      6'h00: begin
        sts.push_back(6); rdys.push_back(1'($urandom));
        sts.push_back(7); rdys.push_back(1'($urandom));
      end
      6'h04: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
      6'h08: begin
        sts.push_back(9);  rdys.push_back(1'($urandom));
        sts.push_back(10); rdys.push_back(1'($urandom));
      end
      6'h02: begin sts.push_back(11); rdys.push_back(1'($urandom)); end
      default: ;
    endcase
    foreach (sts[i])
      cyc(sts[i], rdys[i], (sts[i] == 8) ? z : 1'($urandom), op, (sts[i] == 1) && !legal);
    if (legal) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    checks    = 0;
    failures  = 0;
    exp_cnt   = 32'd0;
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    rst       = 1'b1;
    opcode    = 6'h00;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc(0, 1'b1, 1'b0, 6'h00, 1'b0);
    cyc(0, 1'b1, 1'b0, 6'h00, 1'b0);
    rst = 1'b0;

    run_instr(6'h23, 1'b0, 0, 0);
    run_instr(6'h00, 1'b0, 0, 0);
    run_instr(6'h08, 1'b0, 0, 0);
    chk("count_after_rtype_addi", instr_count, 32'd3);
    run_instr(6'h04, 1'b1, 0, 0);
    run_instr(6'h04, 1'b0, 0, 0);
    run_instr(6'h02, 1'b0, 0, 0);
    run_instr(6'h00, 1'b0, 3, 0);
    run_instr(6'h2B, 1'b0, 0, 2);
    run_instr(6'h3F, 1'b0, 0, 0);
    run_instr(6'h23, 1'b0, 1, 3);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) < 6) begin
        op = legal_ops[$urandom_range(0, 5)];
      end else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset in the middle of a stalled load
    cyc(0, 1'b1, 1'b0, 6'h23, 1'b0);
    cyc(1, 1'b1, 1'b0, 6'h23, 1'b0);
    cyc(2, 1'b1, 1'b0, 6'h23, 1'b0);
    cyc(3, 1'b0, 1'b0, 6'h23, 1'b0);
    rst = 1'b1;
    cyc(3, 1'b0, 1'b0, 6'h23, 1'b0);
    exp_cnt = 32'd0;
    cyc(0, 1'b1, 1'b0, 6'h23, 1'b0);
    cyc(0, 1'b0, 1'b0, 6'h23, 1'b0);
    rst = 1'b0;
    run_instr(6'h23, 1'b0, 0, 0);
    run_instr(6'h02, 1'b0, 0, 0);
    chk("state_final", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
